// File: rtl/usb_pkt_encoder_if.sv
// Packet request bus from the protocol FSM plus the serial line-side outputs of the encoder.
interface usb_pkt_encoder_if;
  logic        pktready;
  logic [3:0]  pid_out;
  logic [6:0]  addr_out;
  logic [3:0]  endp_out;
  logic [63:0] data_out;
  logic        down_ready;
  logic        bit_out;
  logic        bit_en;
  logic        eop_out;

  modport master (
    output pktready, pid_out, addr_out, endp_out, data_out,
    input  down_ready, bit_out, bit_en, eop_out
  );

  modport slave (
    input  pktready, pid_out, addr_out, endp_out, data_out,
    output down_ready, bit_out, bit_en, eop_out
  );
endinterface

// File: rtl/usb_pkt_encoder.sv
// USB packet encoder: serialises SYNC, PID, payload and CRC5/CRC16 with bit stuffing,
// then a two-cycle EOP marker. All outputs come straight from flops.
module usb_pkt_encoder (
  input  logic            clk,
  input  logic            rst_L,
  usb_pkt_encoder_if.slave bus
);

  localparam int unsigned IDX_W     = 7;
  localparam int unsigned SYNC_LEN  = 8;
  localparam int unsigned PID_LEN   = 8;
  localparam int unsigned ADDR_W    = 7;
  localparam int unsigned TOK_LEN   = 11;
  localparam int unsigned DAT_LEN   = 64;
  localparam int unsigned CRC5_W    = 5;
  localparam int unsigned CRC16_W   = 16;
  localparam int unsigned EOP_LEN   = 2;
  localparam int unsigned ONES_W    = 3;
  localparam int unsigned STUFF_RUN = 6;

  typedef enum logic [2:0] {
    S_IDLE, S_SYNC, S_PID, S_BODY, S_CRC, S_EOP
  } state_t;

  typedef enum logic [1:0] {
    C_HS, C_TOK, C_DAT
  } pclass_t;

  state_t             state_q, state_nx;
  logic [IDX_W-1:0]   idx_q, idx_nx;
  logic               stuff_q, stuff_nx;
  logic [ONES_W-1:0]  ones_q, ones_nx, ones_after;
  logic [CRC16_W-1:0] crc_q, crc_nx;
  logic [CRC5_W-1:0]  crc5_upd;
  logic               fb5, fb16;
  pclass_t            cls_q, cls_nx;
  logic [3:0]         pid_q, pid_nx;
  logic [6:0]         addr_q, addr_nx;
  logic [3:0]         endp_q, endp_nx;
  logic [63:0]        data_q, data_nx;
  logic               emitting, cur_bit;
  logic [IDX_W-1:0]   last_idx;
  logic               down_ready_q, bit_out_q, bit_en_q, eop_out_q;
  logic               down_ready_nx, bit_out_nx, bit_en_nx, eop_out_nx;

  function automatic pclass_t decode_class(input logic [3:0] pid);
    pclass_t c;
    case (pid)
      4'b0001, 4'b1001, 4'b1101: c = C_TOK;
      4'b0011, 4'b1011:          c = C_DAT;
      default:                   c = C_HS;
    endcase
    return c;
  endfunction

  // Unstuffed line bit for a given field position; CRC is sent inverted, MSB first.
  function automatic logic field_bit(input state_t st, input logic [IDX_W-1:0] idx,
                                     input pclass_t cls, input logic [3:0] pid,
                                     input logic [6:0] addr, input logic [3:0] endp,
                                     input logic [63:0] data, input logic [CRC16_W-1:0] crc);
    logic       b;
    logic [1:0] eo;
    logic [3:0] co;
    b  = 1'b0;
    eo = idx[1:0] - 2'd3;
    co = ((cls == C_TOK) ? 4'(CRC5_W - 1) : 4'(CRC16_W - 1)) - idx[3:0];
    case (st)
      S_SYNC: b = (idx == IDX_W'(SYNC_LEN - 1));
      S_PID:  b = idx[2] ? ~pid[idx[1:0]] : pid[idx[1:0]];
      S_BODY: begin
        if (cls == C_TOK) b = (idx < IDX_W'(ADDR_W)) ? addr[idx[2:0]] : endp[eo];
        else              b = data[idx[5:0]];
      end
      S_CRC:  b = ~crc[co];
      default: b = 1'b0;
    endcase
    return b;
  endfunction

  // State, field and output registers.
  always_ff @(posedge clk or negedge rst_L) begin
    if (!rst_L) begin
      state_q      <= S_IDLE;
      idx_q        <= '0;
      stuff_q      <= 1'b0;
      ones_q       <= '0;
      crc_q        <= '0;
      cls_q        <= C_HS;
      pid_q        <= '0;
      addr_q       <= '0;
      endp_q       <= '0;
      data_q       <= '0;
      down_ready_q <= 1'b1;
      bit_out_q    <= 1'b0;
      bit_en_q     <= 1'b0;
      eop_out_q    <= 1'b0;
    end else begin
      state_q      <= state_nx;
      idx_q        <= idx_nx;
      stuff_q      <= stuff_nx;
      ones_q       <= ones_nx;
      crc_q        <= crc_nx;
      cls_q        <= cls_nx;
      pid_q        <= pid_nx;
      addr_q       <= addr_nx;
      endp_q       <= endp_nx;
      data_q       <= data_nx;
      down_ready_q <= down_ready_nx;
      bit_out_q    <= bit_out_nx;
      bit_en_q     <= bit_en_nx;
      eop_out_q    <= eop_out_nx;
    end
  end

  always_comb begin
    state_nx   = state_q;
    idx_nx     = idx_q;
    stuff_nx   = stuff_q;
    ones_nx    = ones_q;
    crc_nx     = crc_q;
    cls_nx     = cls_q;
    pid_nx     = pid_q;
    addr_nx    = addr_q;
    endp_nx    = endp_q;
    data_nx    = data_q;
    emitting   = 1'b0;
    cur_bit    = 1'b0;
    ones_after = '0;
    fb5        = 1'b0;
    fb16       = 1'b0;
    crc5_upd   = '0;
    last_idx   = '0;

    case (state_q)
      S_IDLE: begin
        if (bus.pktready) begin
          pid_nx   = bus.pid_out;
          addr_nx  = bus.addr_out;
          endp_nx  = bus.endp_out;
          data_nx  = bus.data_out;
          cls_nx   = decode_class(bus.pid_out);
          crc_nx   = '1;
          idx_nx   = '0;
          stuff_nx = 1'b0;
          ones_nx  = '0;
          state_nx = S_SYNC;
        end
      end
      S_SYNC, S_PID, S_BODY, S_CRC: emitting = 1'b1;
      S_EOP: begin
        // A stuff bit owed by the final data bit goes out before the marker.
        if (stuff_q) begin
          emitting = 1'b1;
        end else if (idx_q == IDX_W'(EOP_LEN - 1)) begin
          idx_nx   = '0;
          state_nx = S_IDLE;
        end else begin
          idx_nx = idx_q + 1'b1;
        end
      end
      default: state_nx = S_IDLE;
    endcase

    case (state_q)
      S_SYNC:  last_idx = IDX_W'(SYNC_LEN - 1);
      S_PID:   last_idx = IDX_W'(PID_LEN - 1);
      S_BODY:  last_idx = (cls_q == C_TOK) ? IDX_W'(TOK_LEN - 1) : IDX_W'(DAT_LEN - 1);
      S_CRC:   last_idx = (cls_q == C_TOK) ? IDX_W'(CRC5_W - 1) : IDX_W'(CRC16_W - 1);
      default: last_idx = '0;
    endcase

    if (emitting) begin
      cur_bit    = stuff_q ? 1'b0
                           : field_bit(state_q, idx_q, cls_q, pid_q, addr_q, endp_q, data_q, crc_q);
      ones_after = cur_bit ? ones_q + 1'b1 : '0;
      stuff_nx   = (ones_after == ONES_W'(STUFF_RUN));
      ones_nx    = stuff_nx ? '0 : ones_after;
      // Stuffed bits neither advance the field index nor enter the CRC.
      if (!stuff_q) begin
        if (state_q == S_BODY) begin
          fb5      = crc_q[CRC5_W-1] ^ cur_bit;
          crc5_upd = {crc_q[CRC5_W-2:0], 1'b0} ^ (fb5 ? 5'b00101 : 5'b00000);
          fb16     = crc_q[CRC16_W-1] ^ cur_bit;
          crc_nx   = (cls_q == C_TOK) ? {11'b0, crc5_upd}
                                      : ({crc_q[CRC16_W-2:0], 1'b0} ^ (fb16 ? 16'h8005 : 16'h0000));
        end
        if (idx_q == last_idx) begin
          idx_nx = '0;
          case (state_q)
            S_SYNC:  state_nx = S_PID;
            S_PID:   state_nx = (cls_q == C_HS) ? S_EOP : S_BODY;
            S_BODY:  state_nx = S_CRC;
            default: state_nx = S_EOP;
          endcase
        end else begin
          idx_nx = idx_q + 1'b1;
        end
      end
    end

    // Outputs for the next cycle, decoded from the next-state values.
    down_ready_nx = (state_nx == S_IDLE);
    bit_en_nx     = (state_nx == S_SYNC) || (state_nx == S_PID) || (state_nx == S_BODY) ||
                    (state_nx == S_CRC)  || ((state_nx == S_EOP) && stuff_nx);
    eop_out_nx    = (state_nx == S_EOP) && !stuff_nx;
    bit_out_nx    = bit_en_nx && !stuff_nx &&
                    field_bit(state_nx, idx_nx, cls_nx, pid_nx, addr_nx, endp_nx, data_nx, crc_nx);
  end

  assign bus.down_ready = down_ready_q;
  assign bus.bit_out    = bit_out_q;
  assign bus.bit_en     = bit_en_q;
  assign bus.eop_out    = eop_out_q;

endmodule
